// File: rtl/sd_mount_pkg.sv
// Shared types and default timing constants for the virtual SD mount controller.
package sd_mount_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } sd_mount_state_t;

    localparam int HOLD_CYCLES_DEF = 10000000;
    localparam int DRAIN_MAX_DEF   = 65535;
    localparam int ACT_CYCLES_DEF  = 1000000;

endpackage

// File: rtl/sd_mount_ctrl_if.sv
// Signal bundle between mist_io / tsconf SPI / sd_card and the mount controller.
interface sd_mount_ctrl_if;

    // img_mounted is a one-cycle strobe qualifying img_size; there is no ready:
    // the controller accepts a strobe in every state and never stalls the source.
    logic        img_mounted;
    logic [63:0] img_size;
    logic        spi_ss_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        vsd_sel;
    logic        vsd_ss_n;
    logic        reset_req;
    logic        sd_act;
    logic [1:0]  state_o;

    modport master (
        output img_mounted, img_size, spi_ss_n, spi_mosi, spi_miso,
        input  vsd_sel, vsd_ss_n, reset_req, sd_act, state_o
    );

    modport slave (
        input  img_mounted, img_size, spi_ss_n, spi_mosi, spi_miso,
        output vsd_sel, vsd_ss_n, reset_req, sd_act, state_o
    );

endinterface

// File: rtl/sd_act_timer.sv
// SPI line edge detector plus saturating stretch timer driving the SD activity LED.
module sd_act_timer
    import sd_mount_pkg::*;
#(
    parameter int ACT_CYCLES = ACT_CYCLES_DEF
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic spi_mosi,
    input  logic spi_miso,
    output logic sd_act
);

    localparam int TW = $clog2(ACT_CYCLES + 1);
    localparam logic [TW-1:0] ACT_MAX = TW'(ACT_CYCLES);

    logic          mosi_q;
    logic          miso_q;
    logic          edge_q;
    logic [TW-1:0] timer_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mosi_q  <= 1'b0;
            miso_q  <= 1'b0;
            edge_q  <= 1'b0;
            timer_q <= ACT_MAX;
        end else begin
            mosi_q <= spi_mosi;
            miso_q <= spi_miso;
            edge_q <= (spi_mosi ^ mosi_q) | (spi_miso ^ miso_q);
            // Timer parks at ACT_MAX, which is the "idle" value seen after reset.
            if (edge_q) begin
                timer_q <= '0;
            end else if (timer_q != ACT_MAX) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign sd_act = (timer_q < ACT_MAX);

endmodule

// File: rtl/sd_mount_ctrl.sv
// Virtual SD mount sequencer: drains SPI, holds core cold reset, gates card select.
// Optional SD activity LED logic is built when SD_ACT_LED_EN is defined.
module sd_mount_ctrl
    import sd_mount_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int DRAIN_MAX   = DRAIN_MAX_DEF,
    parameter int ACT_CYCLES  = ACT_CYCLES_DEF
) (
    input  logic            clk_sys,
    input  logic            reset,
    sd_mount_ctrl_if.slave  bus
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = (DRAIN_MAX > 0) ? $clog2(DRAIN_MAX + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [DW:0]   DRAIN_LIM = (DW + 1)'(DRAIN_MAX);

    if (HOLD_CYCLES < 1 || ACT_CYCLES < 1) begin : g_param_check
        $error("sd_mount_ctrl: HOLD_CYCLES and ACT_CYCLES must be >= 1");
    end

    sd_mount_state_t state_q, state_d;
    logic            pend_sel_q, pend_sel_d;
    logic            vsd_sel_q, vsd_sel_d;
    logic            reset_req_q, reset_req_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [DW:0]     drain_inc;
    logic            mount_sel;
    logic            enter_hold;
    logic            enter_sel;

    assign mount_sel = |bus.img_size;
    assign drain_inc = {1'b0, drain_cnt_q} + (DW + 1)'(1);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= RUN;
            pend_sel_q  <= 1'b0;
            vsd_sel_q   <= 1'b0;
            reset_req_q <= 1'b0;
            hold_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_sel_q  <= pend_sel_d;
            vsd_sel_q   <= vsd_sel_d;
            reset_req_q <= reset_req_d;
            hold_cnt_q  <= hold_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_sel_d  = pend_sel_q;
        vsd_sel_d   = vsd_sel_q;
        reset_req_d = reset_req_q;
        hold_cnt_d  = hold_cnt_q;
        drain_cnt_d = drain_cnt_q;
        enter_hold  = 1'b0;
        enter_sel   = pend_sel_q;

        case (state_q)
            RUN: begin
                if (bus.img_mounted) begin
                    pend_sel_d = mount_sel;
                    enter_sel  = mount_sel;
                    if (bus.spi_ss_n) begin
                        enter_hold = 1'b1;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                // A late mount replaces the latched presence but keeps the drain deadline.
                drain_cnt_d = drain_inc[DW-1:0];
                if (bus.img_mounted) begin
                    pend_sel_d = mount_sel;
                    enter_sel  = mount_sel;
                end
                if (bus.spi_ss_n || (drain_inc >= DRAIN_LIM)) begin
                    enter_hold = 1'b1;
                end
            end
            HOLD: begin
                // A mount in the final hold cycle still wins over the exit to RUN.
                if (bus.img_mounted) begin
                    pend_sel_d = mount_sel;
                    vsd_sel_d  = mount_sel;
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d     = RUN;
                    reset_req_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            default: begin
                state_d     = RUN;
                reset_req_d = 1'b0;
            end
        endcase

        if (enter_hold) begin
            state_d     = HOLD;
            vsd_sel_d   = enter_sel;
            hold_cnt_d  = HOLD_LOAD;
            reset_req_d = 1'b1;
        end
    end

    assign bus.vsd_sel   = vsd_sel_q;
    assign bus.reset_req = reset_req_q;
    assign bus.state_o   = state_q;
    assign bus.vsd_ss_n  = ~vsd_sel_q | bus.spi_ss_n | (state_q == HOLD);

    logic sd_act_w;

`ifdef SD_ACT_LED_EN
    sd_act_timer #(
        .ACT_CYCLES(ACT_CYCLES)
    ) u_act_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .spi_mosi(bus.spi_mosi),
        .spi_miso(bus.spi_miso),
        .sd_act  (sd_act_w)
    );
`else
    assign sd_act_w = 1'b0;
`endif

    assign bus.sd_act = sd_act_w;

endmodule

// File: tb/tb_sd_mount_ctrl.sv
// Self-checking bench for sd_mount_ctrl: scenario table, activity sequences, random vs. model.
module tb_sd_mount_ctrl;

  localparam int P_HOLD  = 16;
  localparam int P_DRAIN = 8;
  localparam int P_ACT   = 10;
  localparam int WIN     = 30;
  localparam int N_RND   = 3000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_mount_ctrl_if bus();

  sd_mount_ctrl #(
    .HOLD_CYCLES(P_HOLD),
    .DRAIN_MAX  (P_DRAIN),
    .ACT_CYCLES (P_ACT)
  ) dut (
    .clk_sys(clk),
    .reset  (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] s_state;
  logic       s_sel, s_req, s_ssn, s_act;
  logic       tb_mo = 1'b0;
  logic       tb_mi = 1'b0;

  // scoreboard: expected {state[1:0], sel, req, ss_n, act}
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock cycle with the given inputs, outputs sampled mid-cycle
  task automatic step(input logic r, input logic m, input logic [63:0] sz,
                      input logic ss, input logic mo, input logic mi);
    @(posedge clk);
    #1;
    rst             = r;
    bus.img_mounted = m;
    bus.img_size    = sz;
    bus.spi_ss_n    = ss;
    bus.spi_mosi    = mo;
    bus.spi_miso    = mi;
    #1;
    s_state = bus.state_o;
    s_sel   = bus.vsd_sel;
    s_req   = bus.reset_req;
    s_ssn   = bus.vsd_ss_n;
    s_act   = bus.sd_act;
  endtask

  typedef struct {
    string       name;
    logic [63:0] size;
    int          release_at;
    int          eject_at;
    int          reset_at;
    int          exp_first;
    int          exp_last;
    logic        exp_sel_end;
  } scen_t;

  scen_t scen[7];

  // reference model state (absolute cycle stamps)
  int   hold_end, drain_limit, last_edge;
  logic m_sel, m_pend, p_mo, p_mi;

  function automatic logic exp_act(input int n, input int le);
`ifdef SD_ACT_LED_EN
    return (le >= 0) && (n >= le + 2) && (n <= le + P_ACT + 1);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, viol;
    logic m, r, ss, mo, mi, nz, hold, drain;
    logic [63:0] sz;
    logic [5:0] e, got;

    scen[0] = '{"idle",     64'd512, 0,    -1, -1, 1, 16, 1'b1};
    scen[1] = '{"drain",    64'd512, 5,    -1, -1, 6, 21, 1'b1};
    scen[2] = '{"timeout",  64'd512, 1000, -1, -1, 9, 24, 1'b1};
    scen[3] = '{"eject",    64'd512, 0,     4, -1, 1, 20, 1'b0};
    scen[4] = '{"rst_hold", 64'd512, 0,    -1,  3, 1,  3, 1'b0};
    scen[5] = '{"size0",    64'd0,   0,    -1, -1, 1, 16, 1'b0};
    scen[6] = '{"size_msb", 64'h8000_0000_0000_0000, 2, -1, -1, 3, 18, 1'b1};

    bus.img_mounted = 1'b0;
    bus.img_size    = '0;
    bus.spi_ss_n    = 1'b1;
    bus.spi_mosi    = 1'b0;
    bus.spi_miso    = 1'b0;

    // reset state
    repeat (3) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("reset.state", s_state, 0);
    check("reset.sel", s_sel, 0);
    check("reset.req", s_req, 0);
    check("reset.ss_n", s_ssn, 1);
    check("reset.act", s_act, 0);

    // table-driven mount scenarios
    for (int i = 0; i < 7; i++) begin
      repeat (3) step(1'b0, 1'b0, '0, 1'b1, tb_mo, tb_mi);
      first = -1;
      last  = -1;
      viol  = 0;
      for (int k = 0; k < WIN; k++) begin
        m  = (k == 0) || (k == scen[i].eject_at);
        sz = (k == scen[i].eject_at) ? 64'd0 : scen[i].size;
        r  = (k == scen[i].reset_at);
        ss = (k >= scen[i].release_at);
        step(r, m, sz, ss, tb_mo, tb_mi);
        if (s_req === 1'b1) begin
          if (first < 0) first = k;
          last = k;
          if (s_ssn !== 1'b1) viol++;
        end
        if (k == 1 && scen[i].release_at > 1)
          check($sformatf("%s.drain_state", scen[i].name), s_state, 1);
        if (k == scen[i].exp_first) begin
          check($sformatf("%s.hold_state", scen[i].name), s_state, 2);
          check($sformatf("%s.hold_sel", scen[i].name), s_sel, scen[i].size != 0);
        end
        if (k == WIN - 1) begin
          check($sformatf("%s.end_state", scen[i].name), s_state, 0);
          check($sformatf("%s.end_sel", scen[i].name), s_sel, scen[i].exp_sel_end);
        end
      end
      check($sformatf("%s.req_first", scen[i].name), first, scen[i].exp_first);
      check($sformatf("%s.req_last", scen[i].name), last, scen[i].exp_last);
      check($sformatf("%s.ss_n_in_hold", scen[i].name), viol, 0);
    end

    // activity stretch: single MOSI toggle, then single MISO toggle
    for (int j = 0; j < 2; j++) begin
      repeat (P_ACT + 4) step(1'b0, 1'b0, '0, 1'b1, tb_mo, tb_mi);
      if (j == 0) tb_mo = ~tb_mo;
      else        tb_mi = ~tb_mi;
      for (int k = 0; k < 15; k++) begin
        step(1'b0, 1'b0, '0, 1'b1, tb_mo, tb_mi);
        check($sformatf("act%0d.k%0d", j, k), s_act, exp_act(k, 0));
      end
    end

    // randomized run against the reference model
    step(1'b1, 1'b0, '0, 1'b1, tb_mo, tb_mi);
    hold_end    = -1;
    drain_limit = -1;
    last_edge   = -1;
    m_sel  = 1'b0;
    m_pend = 1'b0;
    p_mo   = 1'b0;
    p_mi   = 1'b0;
    ss = 1'b1;
    mo = tb_mo;
    mi = tb_mi;
    for (int n = 0; n < N_RND; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      m  = ($urandom_range(0, 24) == 0);
      sz = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0)  ss = ~ss;
      if ($urandom_range(0, 19) == 0) mo = ~mo;
      if ($urandom_range(0, 39) == 0) mi = ~mi;
      step(r, m, sz, ss, mo, mi);

      hold  = (n <= hold_end);
      drain = !hold && (drain_limit >= 0);
      e[5:4] = hold ? 2'd2 : (drain ? 2'd1 : 2'd0);
      e[3]   = m_sel;
      e[2]   = hold;
      e[1]   = !m_sel || ss || hold;
      e[0]   = exp_act(n, last_edge);
      exp_q.push_back(e);

      got = {s_state, s_sel, s_req, s_ssn, s_act};
      e = exp_q.pop_front();
      check("rnd.state", got[5:4], e[5:4]);
      check("rnd.sel", got[3], e[3]);
      check("rnd.req", got[2], e[2]);
      check("rnd.ss_n", got[1], e[1]);
      check("rnd.act", got[0], e[0]);

      if (r) begin
        hold_end    = -1;
        drain_limit = -1;
        last_edge   = -1;
        m_sel  = 1'b0;
        m_pend = 1'b0;
        p_mo   = 1'b0;
        p_mi   = 1'b0;
      end else begin
        if (mo != p_mo || mi != p_mi) last_edge = n;
        p_mo = mo;
        p_mi = mi;
        nz = (sz != 64'd0);
        if (hold) begin
          if (m) begin
            m_sel    = nz;
            m_pend   = nz;
            hold_end = n + P_HOLD;
          end
        end else if (drain) begin
          if (m) m_pend = nz;
          if (ss || (n + 1 >= drain_limit)) begin
            hold_end    = n + P_HOLD;
            m_sel       = m_pend;
            drain_limit = -1;
          end
        end else if (m) begin
          m_pend = nz;
          if (ss) begin
            hold_end = n + P_HOLD;
            m_sel    = nz;
          end else begin
            drain_limit = n + 1 + P_DRAIN;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
